// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the MIPS-32 fetch-stage PC/NPC unit.
// The alignment helper is used wherever a redirect target is qualified.
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int unsigned DEF_ADDR_W    = 12;
   localparam int unsigned DEF_INC       = 4;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

   // A target is aligned when its low log2(inc) bits are zero; inc is a power of 2.
   function automatic logic align_ok(input logic [31:0] target, input int unsigned inc);
      return (target & (inc - 32'd1)) == 32'd0;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect/stall controls in, fetch address and status out.
// The master side is the pipeline control, the slave side is the PC unit.
interface pc_fetch_unit_if
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] npc_out;
   logic              fetch_valid;
   logic              flush;
   logic              misalign_err;
   logic [ADDR_W-1:0] epc_out;

   modport master (
      output stall, branch_taken, branch_target, jump, jump_target,
      input  pc_out, npc_out, fetch_valid, flush, misalign_err, epc_out
   );

   modport slave (
      input  stall, branch_taken, branch_target, jump, jump_target,
      output pc_out, npc_out, fetch_valid, flush, misalign_err, epc_out
   );

endinterface

// File: rtl/pc_fetch_unit_redirect_arb.sv
// Combinational redirect arbiter: picks live/pending branch or jump, else PC+INC,
// and qualifies the chosen redirect against instruction alignment.
module pc_fetch_unit_redirect_arb
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W  = DEF_ADDR_W,
   parameter int unsigned       INC     = DEF_INC,
   parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              pend_valid,
   input  logic              pend_is_br,
   input  logic [ADDR_W-1:0] pend_tgt,
   output logic [ADDR_W-1:0] target,
   output logic              is_redirect,
   output logic              sel_is_br,
   output logic              misalign,
   output logic [ADDR_W-1:0] next_pc
);

   // Order: live branch, pending branch, live jump, pending jump. The same
   // ranking serves both the overwrite rule while stalled and the apply rule.
   always_comb begin
      // NOTE: every output is given a default first so no latch can be inferred.
      target      = pc + ADDR_W'(INC);
      is_redirect = 1'b0;
      sel_is_br   = 1'b0;
      if (branch_taken) begin
         target      = branch_target;
         is_redirect = 1'b1;
         sel_is_br   = 1'b1;
      end else if (pend_valid && pend_is_br) begin
         target      = pend_tgt;
         is_redirect = 1'b1;
         sel_is_br   = 1'b1;
      end else if (jump) begin
         target      = jump_target;
         is_redirect = 1'b1;
      end else if (pend_valid) begin
         target      = pend_tgt;
         is_redirect = 1'b1;
      end
      misalign = is_redirect && !align_ok(32'(target), INC);
      next_pc  = misalign ? EXC_VEC : target;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS-32 fetch-stage PC/NPC register pair with stall, buffered redirect
// and misaligned-target trap to the exception vector.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter int unsigned       INC       = DEF_INC,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC)
) (
   input logic           clk,
   input logic           rst,
   pc_fetch_unit_if.slave bus
);

   localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] npc;
   logic [ADDR_W-1:0] pend_tgt;
   logic              pend_is_br;
   logic [ADDR_W-1:0] epc;
   logic              fetch_valid;
   logic              flush;
   logic              misalign_err;

   logic [ADDR_W-1:0] arb_target;
   logic              arb_is_redirect;
   logic              arb_sel_is_br;
   logic              arb_misalign;
   logic [ADDR_W-1:0] arb_next_pc;

   pc_fetch_unit_redirect_arb #(
      .ADDR_W (ADDR_W),
      .INC    (INC),
      .EXC_VEC(EXC_VEC)
   ) u_arb (
      .pc           (pc),
      .branch_taken (bus.branch_taken),
      .branch_target(bus.branch_target),
      .jump         (bus.jump),
      .jump_target  (bus.jump_target),
      .pend_valid   (state == ST_HOLD),
      .pend_is_br   (pend_is_br),
      .pend_tgt     (pend_tgt),
      .target       (arb_target),
      .is_redirect  (arb_is_redirect),
      .sel_is_br    (arb_sel_is_br),
      .misalign     (arb_misalign),
      .next_pc      (arb_next_pc)
   );

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register see pre-edge values.
      if (rst) begin
         state        <= ST_BOOT;
         pc           <= RESET_VEC;
         npc          <= RESET_VEC + INC_W;
         // NOTE: the pending buffer is reset too, so a redirect never survives reset.
         pend_tgt     <= '0;
         pend_is_br   <= 1'b0;
         epc          <= '0;
         fetch_valid  <= 1'b0;
         flush        <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         flush        <= 1'b0;
         misalign_err <= 1'b0;
         unique case (state)
            ST_BOOT: begin
               state       <= ST_RUN;
               fetch_valid <= 1'b1;
            end
            ST_RUN, ST_HOLD: begin
               if (bus.stall) begin
                  // While held, the arbiter's pick is exactly the new pending entry.
                  if (arb_is_redirect) begin
                     pend_tgt   <= arb_target;
                     pend_is_br <= arb_sel_is_br;
                     state      <= ST_HOLD;
                  end
               end else begin
                  pc         <= arb_next_pc;
                  npc        <= arb_next_pc + INC_W;
                  pend_tgt   <= '0;
                  pend_is_br <= 1'b0;
                  state      <= ST_RUN;
                  flush      <= arb_is_redirect;
                  if (arb_misalign) begin
                     misalign_err <= 1'b1;
                     epc          <= arb_target;
                  end
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

   assign bus.pc_out       = pc;
   assign bus.npc_out      = npc;
   assign bus.fetch_valid  = fetch_valid;
   assign bus.flush        = flush;
   assign bus.misalign_err = misalign_err;
   assign bus.epc_out      = epc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random traffic,
// checked against a queue-based model of the redirect-buffer rules.
module tb_pc_fetch_unit;

   localparam logic [11:0] RESET_V = 12'h000;
   localparam logic [11:0] EXC_V   = 12'h180;
   localparam logic [11:0] INC_L   = 12'd4;

   typedef struct {
      logic [11:0] pc;
      logic [11:0] npc;
      logic        fv;
      logic        fl;
      logic        me;
      logic [11:0] epc;
   } exp_t;

   typedef struct {
      logic [11:0] tgt;
      bit          is_br;
   } redir_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   exp_t   exp_q[$];
   redir_t pend_q[$];

   logic [11:0] m_pc   = RESET_V;
   logic [11:0] m_epc  = '0;
   bit          m_boot = 1'b1;
   bit          m_fv   = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   pc_fetch_unit_if #(.ADDR_W(12)) bus ();

   pc_fetch_unit #(
      .ADDR_W   (12),
      .INC      (4),
      .RESET_VEC(12'h000),
      .EXC_VEC  (12'h180)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference: live redirects first merge into a one-deep pending queue
   // (branch replaces anything, jump replaces only a jump); an unstalled
   // cycle then drains that queue, or falls through to pc+INC.
   task automatic model(input bit r, input bit s, input bit b, input logic [11:0] bt,
                        input bit jj, input logic [11:0] jt);
      exp_t   e;
      redir_t t;
      bit     fl = 1'b0;
      bit     me = 1'b0;
      if (r) begin
         m_pc   = RESET_V;
         m_boot = 1'b1;
         m_fv   = 1'b0;
         m_epc  = '0;
         pend_q.delete();
      end else if (m_boot) begin
         m_boot = 1'b0;
         m_fv   = 1'b1;
      end else begin
         if (b) begin
            pend_q.delete();
            pend_q.push_back('{tgt: bt, is_br: 1'b1});
         end else if (jj && (pend_q.size() == 0 || !pend_q[0].is_br)) begin
            pend_q.delete();
            pend_q.push_back('{tgt: jt, is_br: 1'b0});
         end
         if (!s) begin
            if (pend_q.size() != 0) begin
               t  = pend_q.pop_front();
               fl = 1'b1;
               if ((t.tgt % 4) != 0) begin
                  m_pc  = EXC_V;
                  me    = 1'b1;
                  m_epc = t.tgt;
               end else begin
                  m_pc = t.tgt;
               end
            end else begin
               m_pc = m_pc + INC_L;
            end
         end
      end
      e.pc  = m_pc;
      e.npc = m_pc + INC_L;
      e.fv  = m_fv;
      e.fl  = fl;
      e.me  = me;
      e.epc = m_epc;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit r, input bit s, input bit b, input logic [11:0] bt,
                       input bit jj, input logic [11:0] jt);
      @(negedge clk);
      rst               = r;
      bus.stall         = s;
      bus.branch_taken  = b;
      bus.branch_target = bt;
      bus.jump          = jj;
      bus.jump_target   = jt;
      model(r, s, b, bt, jj, jt);
   endtask

   task automatic check(input string name, input exp_t e);
      n_tests++;
      if (bus.pc_out !== e.pc || bus.npc_out !== e.npc || bus.fetch_valid !== e.fv ||
          bus.flush !== e.fl || bus.misalign_err !== e.me || bus.epc_out !== e.epc) begin
         n_fail++;
         $display("FAIL %s: got pc=%h npc=%h fv=%b flush=%b merr=%b epc=%h, want pc=%h npc=%h fv=%b flush=%b merr=%b epc=%h",
                  name, bus.pc_out, bus.npc_out, bus.fetch_valid, bus.flush,
                  bus.misalign_err, bus.epc_out, e.pc, e.npc, e.fv, e.fl, e.me, e.epc);
      end
   endtask

   // Monitor: the unit presents a fresh output set after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("cyc%0d", cyc), e);
         end
      end
   end

   initial begin
      logic [11:0] bt;
      logic [11:0] jt;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;

      // Reset then free-running: BOOT holds pc, then sequential fetch.
      step(1, 0, 0, 12'h000, 0, 12'h000);
      repeat (4) step(0, 0, 0, 12'h000, 0, 12'h000);
      // Branch redirect.
      step(0, 0, 1, 12'h040, 0, 12'h000);
      step(0, 0, 0, 12'h000, 0, 12'h000);
      // Stall with jump then branch buffered; release applies the branch.
      step(0, 1, 0, 12'h000, 1, 12'h100);
      step(0, 1, 1, 12'h200, 0, 12'h000);
      step(0, 1, 0, 12'h000, 0, 12'h000);
      step(0, 0, 0, 12'h000, 0, 12'h000);
      step(0, 0, 0, 12'h000, 0, 12'h000);
      // Branch and jump together: branch wins.
      step(0, 0, 1, 12'h0a0, 1, 12'h0c0);
      // Live misaligned branch traps.
      step(0, 0, 1, 12'h042, 0, 12'h000);
      step(0, 0, 0, 12'h000, 0, 12'h000);
      // Buffered misaligned target traps only on release.
      step(0, 1, 1, 12'h046, 0, 12'h000);
      step(0, 1, 0, 12'h000, 0, 12'h000);
      step(0, 0, 0, 12'h000, 0, 12'h000);
      // Pending branch is not displaced by a later jump.
      step(0, 1, 1, 12'h080, 0, 12'h000);
      step(0, 1, 0, 12'h000, 1, 12'h0f0);
      step(0, 0, 0, 12'h000, 0, 12'h000);
      // Wrap at the top of the address space.
      step(0, 0, 0, 12'h000, 1, 12'hffc);
      repeat (2) step(0, 0, 0, 12'h000, 0, 12'h000);
      // Reset while holding a pending redirect discards it.
      step(0, 1, 1, 12'h300, 0, 12'h000);
      step(1, 1, 0, 12'h000, 0, 12'h000);
      repeat (3) step(0, 0, 0, 12'h000, 0, 12'h000);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         bt = 12'($urandom_range(4095));
         jt = 12'($urandom_range(4095));
         if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
         step($urandom_range(99) < 2, $urandom_range(99) < 35,
              $urandom_range(99) < 15, bt, $urandom_range(99) < 15, jt);
      end
      repeat (3) step(0, 0, 0, 12'h000, 0, 12'h000);

      @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
